guess_btn_cond: RTL
===================

# guess_btn_cond

Input conditioner for the guessing game: turns four raw, bouncy, asynchronous push-buttons into the clean 4-bit button bus `B` consumed by `guess_FSM`. It synchronises, debounces and one-hot-qualifies presses, and requires a full release before it accepts another press. It sits between the board pins and the game FSM, one instance per game.

## Interface
- `DB_CYCLES`, default 1_000_000: number of consecutive stable cycles required to accept a press or a release. Must be ≥ 2.
- `CW`, default `$clog2(DB_CYCLES)`: debounce counter width (derived; do not override).

Ports:
- `clk`  in  1  system clock, one clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `btn_raw`  in  4  raw push-buttons, asynchronous, active-high.
- `B`  out  4  debounced button level to `guess_FSM`, either one-hot or zero.
- `press`  out  4  single-cycle pulse equal to `B` on the first cycle of an accepted press.
- `multi`  out  1  single-cycle pulse when a debounced press has more than one button down; that press is rejected.

## Operation
- **Synchroniser:** two flops per bit. `s2` is `btn_raw` delayed by 2 edges. Only `s2` feeds the FSM.
- **Registers:** `state`, `cand[3:0]`, `cnt[CW-1:0]`, `valid`.
- **States:** IDLE, DEB_PRESS, HELD, DEB_REL.
- **IDLE:** if `s2 != 0`, set `cand <= s2` and `cnt <= 0`, then go to DEB_PRESS. Otherwise stay.
- **DEB_PRESS:**
  - If `s2 != cand`, go to IDLE and clear `cnt`.
  - Otherwise increment `cnt`.
  - When `cnt == DB_CYCLES-1` and `s2 == cand`:
    - If `cand` is one-hot: `valid <= 1`, pulse `press <= cand`, go to HELD.
    - If not: `valid <= 0`, pulse `multi`, go to HELD.
- **HELD:** if `s2 == 0`, set `cnt <= 0` and go to DEB_REL. Any other nonzero pattern (extra or changed buttons) is ignored and no new press is generated.
- **DEB_REL:**
  - If `s2 != 0`, go back to HELD and clear `cnt`.
  - Otherwise increment `cnt`.
  - When `cnt == DB_CYCLES-1`, set `valid <= 0` and go to IDLE.
- **Outputs:** `B = valid ? cand : 4'b0`, registered. `press` and `multi` are registered and high for exactly one cycle.
- **Counter:** `cnt` never exceeds `DB_CYCLES-1`. There is no wrap-around.
- **Reset values:** `state` = IDLE, `cand` = 0, `cnt` = 0, `valid` = 0, synchroniser flops = 0. `B`, `press` and `multi` are all 0. A reset mid-operation discards any press in progress. A button held through the reset is re-debounced as a new press once reset is released.

## Timing
- **Press latency:** `btn_raw` settles before edge 0, and edge 0 is the first edge that samples the new value.
  - `s2` is valid after edge 1.
  - IDLE moves to DEB_PRESS at edge 2.
  - `press` and `B` go high after edge `2+DB_CYCLES`, i.e. on edge number `DB_CYCLES+3` counting edge 0 as the first.
- **Release latency:** `B` falls after the same number of edges following a clean release.
- **Bounce:** any bounce inside a debounce window restarts the window, counted from the bounce.
- **Repeat:** at most one `press` per physical press-release cycle.
- **Simultaneous outputs:** `press` and `multi` are never high together.
- **Reset:** takes effect on the next `clk` edge while `rst` is high. Outputs are 0 on the cycle after that edge.

## Structure
- The `guess_pkg` package holds the `btn_state_t` enum (IDLE, DEB_PRESS, HELD, DEB_REL) and the button-width constant `BTN_W = 4`, shared with `guess_FSM`.
- One sub-module, `sync_2ff #(W)`: a two-flop synchroniser with synchronous active-high reset. It is instantiated once with `W = BTN_W`.
- FSM and datapath live in one `always_ff` block plus one `always_comb` next-state block.

## Test plan
All scenarios use `DB_CYCLES = 4`.
- **Clean press:** `btn_raw = 4'b0100` held steady from edge 0 -> `press = 4'b0100` for one cycle after edge 6, then `B = 4'b0100`. `multi` stays 0.
- **Bouncy press:** `btn_raw = 4'b0010` toggled off/on every 2 cycles for 10 cycles, then stable -> no `press` during the bounce. `press = 4'b0010` occurs 7 edges after the last toggle.
- **Multi-press:** `btn_raw = 4'b0011` stable -> `multi` pulses once after edge 6. `B` and `press` stay 0. After release, `4'b0001` pressed alone gives a normal `press`.
- **Hold and release:** press `4'b1000`, hold for 50 cycles, and press `4'b0001` while held -> single `press`, `B` stays `4'b1000`. After full release, `B = 0` 7 edges after `btn_raw` returns to 0.
- **Release glitch:** during DEB_REL, pulse `btn_raw` to 1 for 1 cycle -> `B` stays asserted and the release window restarts. No second `press` is generated.
- **Reset mid-debounce:** assert `rst` at edge 4 of a press -> `B`, `press` and `multi` are 0 the next cycle. With the button still held after `rst` drops, `press` occurs `DB_CYCLES+3` edges later.

Source files
------------

// File: rtl/guess_pkg.sv
// Shared definitions for the guessing-game button path.
// Holds the button-bus width, the conditioner state encoding and a one-hot
// helper. guess_FSM uses the same package, so BTN_W stays consistent on both sides.
package guess_pkg;

  localparam int BTN_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } btn_state_t;

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [BTN_W-1:0] v);
    return (v != '0) && ((v & (v - BTN_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears both stages
//   d    - asynchronous input bus (W bits)
//   q    - synchronised output, d delayed by two clk edges
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/guess_btn_cond.sv
// Push-button conditioner for the guessing game.
// Synchronises four raw buttons, debounces press and release, accepts only
// single-button presses and requires a full release before the next press.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   btn_raw  - raw asynchronous buttons, active-high
//   B        - debounced level of the accepted button (one-hot or zero)
//   press    - one-cycle pulse equal to B on the first cycle of a press
//   multi    - one-cycle pulse when a debounced press had several buttons down
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | all buttons released, waiting for any button
// DEB_PRESS | candidate pattern seen, counting stable cycles
// HELD      | press resolved (accepted or rejected), waiting for release
// DEB_REL   | all buttons up, counting stable released cycles
module guess_btn_cond
  import guess_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CW        = $clog2(DB_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BTN_W-1:0] btn_raw,
  output logic [BTN_W-1:0] B,
  output logic [BTN_W-1:0] press,
  output logic             multi
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [BTN_W-1:0] s2;
  btn_state_t       state, state_n;
  logic [BTN_W-1:0] cand, cand_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             valid, valid_n;
  logic [BTN_W-1:0] press_n, b_n;
  logic             multi_n;

  sync_2ff #(.W(BTN_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (s2)
  );

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    valid_n = valid;
    press_n = '0;
    multi_n = 1'b0;
    case (state)
      IDLE: begin
        if (s2 != '0) begin
          cand_n  = s2;
          cnt_n   = '0;
          state_n = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (s2 != cand) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          state_n = HELD;
          if (is_onehot(cand)) begin
            valid_n = 1'b1;
            press_n = cand;
          end else begin
            valid_n = 1'b0;
            multi_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HELD: begin
        // Extra or changed buttons while held are deliberately ignored.
        if (s2 == '0) begin
          cnt_n   = '0;
          state_n = DEB_REL;
        end
      end
      DEB_REL: begin
        if (s2 != '0) begin
          cnt_n   = '0;
          state_n = HELD;
        end else if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          valid_n = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        cnt_n   = '0;
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
    // B is registered from next-state values so it rises with press.
    b_n = valid_n ? cand_n : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      B     <= '0;
      press <= '0;
      multi <= 1'b0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
      valid <= valid_n;
      B     <= b_n;
      press <= press_n;
      multi <= multi_n;
    end
  end

endmodule
